sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Shares the single command interface of the SDRAM controller between NPORTS independent requesters (e.g. video fetch, CPU, debug logic) using round-robin arbitration. It sits between the requester ports and the controller's command and read-return path inside `top`. It tracks in-flight reads so that returned read data is steered back to the port that issued each read, in order.

## Interface
- NPORTS, 3: number of requester ports (2..8)
- ADDR_W, 24: word address width ({bank 2, row 13, col 9})
- DATA_W, 16: data width, matching SDRAM_DQ
- MAX_RD, 4: maximum outstanding reads; power of two
- clk  in  1  system clock; the one clock of the block
- rst_n  in  1  asynchronous active-low reset
- p_req  in  NPORTS  per-port request; held with its payload until granted
- p_we  in  NPORTS  per-port write(1)/read(0)
- p_addr  in  NPORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W]
- p_wdata  in  NPORTS*DATA_W  packed write data
- p_gnt  out  NPORTS  one-hot accept; transfer on edge where p_req[i]&p_gnt[i]
- p_rvalid  out  NPORTS  one-hot read-data strobe, one cycle
- p_rdata  out  DATA_W  read data, shared; valid with p_rvalid
- c_valid  out  1  command valid to controller
- c_ready  in  1  controller accepts command
- c_we, c_addr, c_wdata  out  1/ADDR_W/DATA_W  command payload
- c_rvalid  in  1  controller read-data strobe, in issue order
- c_rdata  in  DATA_W  controller read data
- err  out  1  sticky: c_rvalid arrived with no read outstanding

## Operation
- Command register (c_valid, c_we, c_addr, c_wdata) is "free" when c_valid=0 or c_valid&c_ready this cycle.
- Port i is eligible when p_req[i]=1 and (p_we[i]=1 or the tag FIFO can accept: count<MAX_RD or a pop occurs this cycle).
- If the register is free, p_gnt selects the first eligible port searching from last+1 upward with wrap modulo NPORTS; else p_gnt=0. p_gnt is combinational from current inputs and state.
- On grant: payload loads into the command register, c_valid=1 next cycle, last<=granted index; for reads, index is pushed into the tag FIFO.
- If free and no port eligible, c_valid clears after handshake.
- c_rvalid: pop tag FIFO head h; next cycle p_rvalid[h]=1 and p_rdata=c_rdata registered.
- c_rvalid with FIFO empty (and no same-cycle push): no pop, no p_rvalid, err<=1 until reset.
- Writes never wait on tag FIFO state; a full FIFO skips only read requesters in the rotation.

## Timing
- Reset values: p_gnt 0, p_rvalid 0, p_rdata 0, c_valid 0, c_we 0, c_addr 0, c_wdata 0, err 0, last=NPORTS-1 (port 0 first), FIFO empty.
- Request to c_valid: 1 cycle when register free. Sustained throughput 1 command/cycle with c_ready=1.
- c_rvalid to p_rvalid: 1 cycle.
- c_valid and payload stay stable until c_ready (no withdrawal).
- Simultaneous push and pop with FIFO full: allowed, count unchanged.
- Reset mid-operation: command and outstanding reads discarded; later c_rvalid sets err.

## Structure
- Shared package sdram_pkg: ADDR_W/DATA_W defaults, bank/row/col field widths, port index width function (clog2).
- Sub-module sdram_tag_fifo: synchronous FIFO, depth MAX_RD, width clog2(NPORTS), push/pop/full/empty/count, async active-low reset.
- Round-robin search as a combinational loop in the arbiter; no other sub-modules.

## Test plan
- All three ports request writes continuously, c_ready=1 -> grants rotate 0,1,2,0,… one per cycle; c_addr matches granted port.
- Port 1 read addr 0x000123, controller returns 0xBEEF 5 cycles later -> p_rvalid=3'b010, p_rdata=0xBEEF one cycle after c_rvalid.
- Ports 0 and 2 issue 4 reads interleaved, returns in order -> each datum strobes to its issuing port in grant order.
- 4 reads outstanding, port 0 read + port 1 write -> port 1 granted, port 0 waits until a c_rvalid pops.
- c_ready held 0 for 10 cycles -> c_valid/payload stable, p_gnt=0 throughout; resumes next cycle after acceptance.
- c_rvalid with nothing outstanding -> no p_rvalid, err=1 until rst_n low.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM port definitions: default bus widths, address field layout and
// the helper that sizes port-index fields.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;
    localparam int BANK_W       = 2;
    localparam int ROW_W        = 13;
    localparam int COL_W        = 9;

    // Width of a field able to hold a port index 0..n-1 (never narrower than 1 bit).
    function automatic int port_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Tag FIFO that remembers which port issued each in-flight read; an empty FIFO
// with a same-cycle push and pop passes the pushed tag straight through.
module sdram_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bypass, wr, rd;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    assign bypass = push & pop & empty;
    assign wr     = push & ~bypass & (~full | pop);
    assign rd     = pop & ~empty;
    assign dout   = empty ? din : mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + 1'b1;
        end else if (rd && !wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (rd) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller command interface between
// NPORTS requesters, steering returned read data back to the issuing port.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W,
    parameter int MAX_RD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_we,
    input  logic [NPORTS*ADDR_W-1:0] p_addr,
    input  logic [NPORTS*DATA_W-1:0] p_wdata,
    output logic [NPORTS-1:0]        p_gnt,
    output logic [NPORTS-1:0]        p_rvalid,
    output logic [DATA_W-1:0]        p_rdata,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     c_we,
    output logic [ADDR_W-1:0]        c_addr,
    output logic [DATA_W-1:0]        c_wdata,
    input  logic                     c_rvalid,
    input  logic [DATA_W-1:0]        c_rdata,
    output logic                     err
);

    localparam int IDX_W = port_idx_w(NPORTS);
    localparam int CNT_W = $clog2(MAX_RD) + 1;

    logic              c_valid_q, c_valid_d, c_we_q, c_we_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_wdata_q, c_wdata_d, p_rdata_q, p_rdata_d;
    logic [NPORTS-1:0] p_rvalid_q, p_rvalid_d, elig;
    logic [IDX_W-1:0]  last_q, last_d, gnt_idx, head;
    logic              err_q, err_d;
    logic              cmd_free, found, grant, push, pop, pop_ok, rd_room;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    int                cand;

    assign cmd_free = ~c_valid_q | c_ready;
    // A full FIFO still has room if the head is popped this same cycle.
    assign pop_ok   = c_rvalid & ~fifo_empty;
    assign rd_room  = (fifo_count < CNT_W'(MAX_RD)) | pop_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORTS; i++) begin
            elig[i] = p_req[i] & (p_we[i] | rd_room);
        end
    end

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = (int'(last_q) + k) % NPORTS;
            if (!found && elig[IDX_W'(cand)]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

    assign grant = cmd_free & found;
    assign p_gnt = grant ? (NPORTS'(1) << gnt_idx) : '0;
    assign push  = grant & ~p_we[gnt_idx];
    assign pop   = c_rvalid & (~fifo_empty | push);

    always_comb begin
        c_valid_d = c_valid_q;
        c_we_d    = c_we_q;
        c_addr_d  = c_addr_q;
        c_wdata_d = c_wdata_q;
        last_d    = last_q;
        if (cmd_free) begin
            c_valid_d = found;
            if (found) begin
                c_we_d    = p_we[gnt_idx];
                c_addr_d  = p_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                c_wdata_d = p_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                last_d    = gnt_idx;
            end
        end
        p_rvalid_d = pop ? (NPORTS'(1) << head) : '0;
        p_rdata_d  = pop ? c_rdata : p_rdata_q;
        err_d      = err_q | (c_rvalid & fifo_empty & ~push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid_q  <= 1'b0;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            c_wdata_q  <= '0;
            last_q     <= IDX_W'(NPORTS - 1);
            p_rvalid_q <= '0;
            p_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            c_valid_q  <= c_valid_d;
            c_we_q     <= c_we_d;
            c_addr_q   <= c_addr_d;
            c_wdata_q  <= c_wdata_d;
            last_q     <= last_d;
            p_rvalid_q <= p_rvalid_d;
            p_rdata_q  <= p_rdata_d;
            err_q      <= err_d;
        end
    end

    sdram_tag_fifo #(
        .DEPTH(MAX_RD),
        .WIDTH(IDX_W),
        .CNT_W(CNT_W)
    ) u_tag_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (gnt_idx),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign c_valid  = c_valid_q;
    assign c_we     = c_we_q;
    assign c_addr   = c_addr_q;
    assign c_wdata  = c_wdata_q;
    assign p_rvalid = p_rvalid_q;
    assign p_rdata  = p_rdata_q;
    assign err      = err_q;

endmodule
